// File: rtl/conv_row_sched.sv
// Sequencer for the 7-tap row convolution unit: walks a 7x7 valid convolution
// tile by tile (four output columns per tile), accumulating seven row psums per tile.
module conv_row_sched #(
  parameter  int IMG_W = 28,
  parameter  int IMG_H = 28,
  localparam int OUT_W = IMG_W - 6,
  localparam int OUT_H = IMG_H - 6,
  localparam int IR_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int IC_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int OR_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int OT_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [IR_W-1:0] img_row,
  output logic [IC_W-1:0] img_col,
  output logic [2:0]      wt_row,
  output logic            conv_en,
  input  logic [127:0]    psum_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_data,
  output logic [3:0]      out_mask,
  output logic [OR_W-1:0] out_row,
  output logic [OT_W-1:0] out_tile
);

  localparam int NT = (OUT_W + 3) / 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t               state;
  logic [OR_W-1:0]      r;
  logic [OT_W-1:0]      t;
  logic [2:0]           k;
  logic                 drain;
  logic                 acc_en;
  logic [3:0][31:0]     acc;

  logic [OR_W-1:0]      nxt_r;
  logic [OT_W-1:0]      nxt_t;
  logic                 last_tile;
  logic                 launch;

  function automatic logic [3:0] lane_mask(input logic [OT_W-1:0] tile);
    logic [3:0] m;
    m = '0;
    for (int unsigned j = 0; j < 4; j++)
      m[j] = ((4 * int'(tile) + int'(j)) < OUT_W);
    return m;
  endfunction

  // Next tile coordinates are shared by the frame start and the post-handshake restart.
  always_comb begin
    nxt_r     = r;
    nxt_t     = t;
    last_tile = (r == OR_W'(OUT_H - 1)) && (t == OT_W'(NT - 1));
    if (state == S_IDLE) begin
      nxt_r = '0;
      nxt_t = '0;
    end else if (t == OT_W'(NT - 1)) begin
      nxt_r = r + OR_W'(1);
      nxt_t = '0;
    end else begin
      nxt_t = t + OT_W'(1);
    end
    launch = ((state == S_IDLE) && start) ||
             ((state == S_OUT) && out_ready && !last_tile);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      r         <= '0;
      t         <= '0;
      k         <= '0;
      drain     <= 1'b0;
      acc_en    <= 1'b0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      img_row   <= '0;
      img_col   <= '0;
      wt_row    <= '0;
      conv_en   <= 1'b0;
      out_valid <= 1'b0;
      out_mask  <= '0;
    end else begin
      done    <= 1'b0;
      conv_en <= rd_en;
      acc_en  <= conv_en;

      // Masked lanes never accumulate, so lanes past the image edge read out as zero.
      if (acc_en) begin
        for (int unsigned j = 0; j < 4; j++)
          if (out_mask[j])
            acc[j] <= acc[j] + psum_in[32*j +: 32];
      end

      case (state)
        S_IDLE: ;
        S_ISSUE: begin
          if (k == 3'd6) begin
            state   <= S_DRAIN;
            drain   <= 1'b0;
            rd_en   <= 1'b0;
            img_row <= '0;
            img_col <= '0;
            wt_row  <= '0;
          end else begin
            k       <= k + 3'd1;
            wt_row  <= k + 3'd1;
            img_row <= IR_W'(r) + IR_W'(k + 3'd1);
          end
        end
        S_DRAIN: begin
          if (drain) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
          end else begin
            drain <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_tile) begin
              state    <= S_IDLE;
              done     <= 1'b1;
              busy     <= 1'b0;
              r        <= '0;
              t        <= '0;
              acc      <= '0;
              out_mask <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (launch) begin
        state    <= S_ISSUE;
        busy     <= 1'b1;
        r        <= nxt_r;
        t        <= nxt_t;
        k        <= '0;
        rd_en    <= 1'b1;
        img_row  <= IR_W'(nxt_r);
        img_col  <= IC_W'(nxt_t) << 2;
        wt_row   <= '0;
        acc      <= '0;
        out_mask <= lane_mask(nxt_t);
      end
    end
  end

  assign out_data = acc;
  assign out_row  = r;
  assign out_tile = t;

endmodule
